// File: rtl/replica_shift_io.sv
// Host-side shift port of the replica ring.
// Load path: buffers one replica of host words, then emits it as a gap-free
// burst announced by a {PREV,PREV} exchange pulse EXCH_LEAD cycles ahead.
// Unload path: beats leaving the last replica are queued in a FIFO for the host.

package replica_shift_io_pkg;
  typedef enum logic [1:0] {
    EXCH_NOP  = 2'd0,
    EXCH_PREV = 2'd1
  } exchange_command_t;
endpackage

module replica_shift_io
  import replica_shift_io_pkg::*;
#(
  parameter int REPLICA_NUM = 4,
  parameter int CITY_DIV    = 4,
  parameter int LANES       = 8,
  parameter int CITY_W      = 7,
  parameter int EXCH_LEAD   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*CITY_W-1:0]   s_data,
  output logic                      ring_valid,
  output logic [LANES*CITY_W-1:0]   ring_data,
  output exchange_command_t [1:0]   ring_exchange,
  input  logic                      ring_out_valid,
  input  logic [LANES*CITY_W-1:0]   ring_out_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*CITY_W-1:0]   m_data,
  output logic                      overflow
);

  localparam int WORD_W = LANES * CITY_W;
  localparam int DEPTH  = REPLICA_NUM * CITY_DIV;
  localparam int FW     = $clog2(CITY_DIV + 1);
  localparam int BW     = (CITY_DIV > 1) ? $clog2(CITY_DIV) : 1;
  localparam int RW     = (REPLICA_NUM > 1) ? $clog2(REPLICA_NUM) : 1;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  // Pop register plus EXCH_LEAD delay stages: the exchange pulse is registered
  // alongside the pop register, so the beat trails it by exactly EXCH_LEAD.
  localparam int NSTG   = EXCH_LEAD + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]           rep_cnt_q, rep_cnt_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  exchange_command_t [1:0] ring_exchange_q, ring_exchange_d;
  logic [NSTG-1:0]         dl_vld_q, dl_vld_d;
  logic [WORD_W-1:0]       dl_data_q [NSTG];
  logic [WORD_W-1:0]       dl_data_d [NSTG];
  logic [WORD_W-1:0]       load_buf_q [CITY_DIV];
  logic [WORD_W-1:0]       fifo_mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic load_we, pop, last_beat, last_rep, line_busy, accept_start;
  logic fifo_full, fifo_pop, fifo_push, fifo_drop;

  assign accept_start = (state_q == S_IDLE) && start;
  assign pop          = (state_q == S_BURST);
  assign last_beat    = pop && (beat_cnt_q == BW'(CITY_DIV - 1));
  assign last_rep     = (rep_cnt_q == RW'(REPLICA_NUM - 1));
  assign line_busy    = |dl_vld_q;
  assign load_we      = s_valid && s_ready;

  // State register and all control flops (reset applies here only)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      fill_cnt_q      <= '0;
      beat_cnt_q      <= '0;
      rep_cnt_q       <= '0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      ring_exchange_q <= {EXCH_NOP, EXCH_NOP};
      dl_vld_q        <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      fill_cnt_q      <= fill_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      rep_cnt_q       <= rep_cnt_d;
      done_q          <= done_d;
      overflow_q      <= overflow_d;
      ring_exchange_q <= ring_exchange_d;
      dl_vld_q        <= dl_vld_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

  // Data storage: load buffer, delay line payload, unload FIFO memory
  always_ff @(posedge clk) begin
    if (load_we) load_buf_q[fill_cnt_q[BW-1:0]] <= s_data;
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= ring_out_data;
    dl_data_q <= dl_data_d;
  end

  // Next-state logic of the load sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FILL;
      S_FILL:  if (fill_cnt_q == FW'(CITY_DIV)) state_d = S_BURST;
      S_BURST: if (last_beat) state_d = last_rep ? S_DRAIN : S_FILL;
      S_DRAIN: if (!line_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs decoded from the current state
  always_comb begin
    busy    = (state_q != S_IDLE);
    s_ready = (state_q == S_FILL) && (fill_cnt_q < FW'(CITY_DIV));
  end

  // Counters, exchange pulse and burst delay line
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    beat_cnt_d = beat_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    if (load_we) fill_cnt_d = fill_cnt_q + FW'(1);
    if (pop) beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
    if (last_beat) begin
      fill_cnt_d = '0;
      if (!last_rep) rep_cnt_d = rep_cnt_q + RW'(1);
    end
    if (accept_start) begin
      fill_cnt_d = '0;
      beat_cnt_d = '0;
      rep_cnt_d  = '0;
    end
    ring_exchange_d[0] = EXCH_NOP;
    ring_exchange_d[1] = EXCH_NOP;
    if (pop && (beat_cnt_q == '0)) begin
      ring_exchange_d[0] = EXCH_PREV;
      ring_exchange_d[1] = EXCH_PREV;
    end
    dl_vld_d     = {dl_vld_q[NSTG-2:0], pop};
    dl_data_d[0] = load_buf_q[beat_cnt_q];
    for (int i = 1; i < NSTG; i++) dl_data_d[i] = dl_data_q[i-1];
    done_d = (state_q == S_DRAIN) && !line_busy;
  end

  // Unload FIFO bookkeeping; a simultaneous pop frees room for a full-FIFO write
  always_comb begin
    fifo_full  = (fifo_cnt_q == CW'(DEPTH));
    fifo_pop   = m_ready && (fifo_cnt_q != '0);
    fifo_push  = ring_out_valid && (!fifo_full || fifo_pop);
    fifo_drop  = ring_out_valid && fifo_full && !fifo_pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    overflow_d = overflow_q;
    if (fifo_drop) overflow_d = 1'b1;
    if (accept_start) overflow_d = 1'b0;
  end

  assign done          = done_q;
  assign overflow      = overflow_q;
  assign ring_exchange = ring_exchange_q;
  assign ring_valid    = dl_vld_q[NSTG-1];
  assign ring_data     = dl_data_q[NSTG-1];
  assign m_valid       = (fifo_cnt_q != '0);
  assign m_data        = fifo_mem_q[rd_ptr_q];

endmodule
